// File: rtl/mips_pkg.sv
// Shared MIPS definitions used by the fetch stage and the debug unit.
// Holds the datapath width, the fetch FSM state encoding, and the
// reserved HALT and NOP instruction words.
package mips_pkg;

  localparam int unsigned NB_DATA  = 32;
  localparam int unsigned NB_STATE = 2;

  typedef enum logic [NB_STATE-1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  localparam logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [NB_DATA-1:0] NOP_WORD  = 32'h0000_0000;

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction memory: one synchronous write port used by the
// program loader, one asynchronous read port used by fetch. Not reset.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write word address
//   i_wdata  write data
//   i_raddr  read word address
//   o_rdata  read data (combinational)
module instruction_memory #(
  parameter int unsigned NB_ADDR = 8,
  parameter int unsigned NB_DATA = 32
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_DATA-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program loader (byte assembler into instruction memory), PC,
// LOAD/RUN/HALT control and the IF/ID register (instruction, PC+4).
// Ports:
//   clk, i_rst_n          clock, async active-low reset
//   i_load_valid/byte     program byte stream (LOAD only), big-endian per word
//   i_start, i_reload     debug control pulses
//   i_step_en, i_step     single-step mode and advance pulse
//   i_stall               hazard stall (holds PC and IF/ID)
//   i_jump, i_addr2jump   redirect from decode
//   o_instruction, o_pcounter4  IF/ID register
//   o_pc, o_halt, o_state, o_load_words  status
module instruction_fetch #(
  parameter int unsigned             NB_DATA   = mips_pkg::NB_DATA,
  parameter int unsigned             NB_ADDR   = 8,
  parameter logic [NB_DATA-1:0]      HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_load_valid,
  input  logic [7:0]         i_load_byte,
  input  logic               i_start,
  input  logic               i_reload,
  input  logic               i_step_en,
  input  logic               i_step,
  input  logic               i_stall,
  input  logic               i_jump,
  input  logic [NB_DATA-1:0] i_addr2jump,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt,
  output logic [1:0]         o_state,
  output logic [NB_ADDR:0]   o_load_words
);

  import mips_pkg::*;

  localparam logic [NB_ADDR:0]   LW_MAX = {1'b1, {NB_ADDR{1'b0}}};
  localparam logic [NB_DATA-1:0] NOP    = NOP_WORD[NB_DATA-1:0];

  fetch_state_t       r_state;
  logic [NB_DATA-1:0] r_pc;
  logic [NB_DATA-1:0] r_instruction;
  logic [NB_DATA-1:0] r_pcounter4;
  logic               r_halt;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_asm;
  logic [NB_ADDR-1:0] r_load_ptr;
  logic [NB_ADDR:0]   r_load_words;

  logic               w_adv;
  logic               w_we;
  logic [NB_DATA-1:0] w_word;
  logic [NB_ADDR-1:0] w_raddr;
  logic [NB_DATA-1:0] w_rdata;
  logic [NB_DATA-1:0] w_pc4;

  // Advance gating: stall always blocks, step mode needs an i_step pulse
  assign w_adv   = !i_stall && (!i_step_en || i_step);
  // First byte received lands in [31:24]
  assign w_word  = {r_asm, i_load_byte};
  // A start on the 4th-byte cycle discards the word like any partial word
  assign w_we    = (r_state == ST_LOAD) && i_load_valid && !i_start
                   && (r_byte_cnt == 2'd3);
  // Byte PC to word index; bits [1:0] ignored, upper bits wrap
  assign w_raddr = r_pc[NB_ADDR+1:2];
  assign w_pc4   = r_pc + NB_DATA'(4);

  instruction_memory #(
    .NB_ADDR (NB_ADDR),
    .NB_DATA (NB_DATA)
  ) u_imem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_load_ptr),
    .i_wdata (w_word),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Control FSM, loader, PC and IF/ID register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_LOAD;
      r_pc          <= '0;
      r_instruction <= NOP;
      r_pcounter4   <= '0;
      r_halt        <= 1'b0;
      r_byte_cnt    <= '0;
      r_asm         <= '0;
      r_load_ptr    <= '0;
      r_load_words  <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (i_start) begin
            r_state    <= ST_RUN;
            r_pc       <= '0;
            r_byte_cnt <= '0;
          end else if (i_load_valid) begin
            if (r_byte_cnt == 2'd3) begin
              r_byte_cnt <= '0;
              r_load_ptr <= r_load_ptr + NB_ADDR'(1);
              if (r_load_words != LW_MAX) begin
                r_load_words <= r_load_words + (NB_ADDR+1)'(1);
              end
            end else begin
              r_asm      <= {r_asm[15:0], i_load_byte};
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        ST_RUN: begin
          if (w_adv) begin
            if (i_jump) begin
              // Flush the wrong-path slot
              r_pc          <= i_addr2jump;
              r_instruction <= NOP;
              r_pcounter4   <= '0;
            end else if (w_rdata == HALT_WORD) begin
              r_instruction <= NOP;
              r_pcounter4   <= '0;
              r_halt        <= 1'b1;
              r_state       <= ST_HALT;
            end else begin
              r_instruction <= w_rdata;
              r_pcounter4   <= w_pc4;
              r_pc          <= w_pc4;
            end
          end
        end

        ST_HALT: begin
          if (i_start) begin
            r_halt  <= 1'b0;
            r_pc    <= '0;
            r_state <= ST_RUN;
          end else if (i_reload) begin
            r_halt       <= 1'b0;
            r_state      <= ST_LOAD;
            r_byte_cnt   <= '0;
            r_load_ptr   <= '0;
            r_load_words <= '0;
          end
        end

        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign o_instruction = r_instruction;
  assign o_pcounter4   = r_pcounter4;
  assign o_pc          = r_pc;
  assign o_halt        = r_halt;
  assign o_state       = r_state;
  assign o_load_words  = r_load_words;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table-driven RUN sequence plus
// hand-written load/halt/reset/wrap sequences.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_load_valid;
  logic [7:0]  i_load_byte;
  logic        i_start;
  logic        i_reload;
  logic        i_step_en;
  logic        i_step;
  logic        i_stall;
  logic        i_jump;
  logic [31:0] i_addr2jump;
  logic [31:0] o_instruction;
  logic [31:0] o_pcounter4;
  logic [31:0] o_pc;
  logic        o_halt;
  logic [1:0]  o_state;
  logic [8:0]  o_load_words;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_load_valid  (i_load_valid),
    .i_load_byte   (i_load_byte),
    .i_start       (i_start),
    .i_reload      (i_reload),
    .i_step_en     (i_step_en),
    .i_step        (i_step),
    .i_stall       (i_stall),
    .i_jump        (i_jump),
    .i_addr2jump   (i_addr2jump),
    .o_instruction (o_instruction),
    .o_pcounter4   (o_pcounter4),
    .o_pc          (o_pc),
    .o_halt        (o_halt),
    .o_state       (o_state),
    .o_load_words  (o_load_words)
  );

  typedef struct {
    logic        stall;
    logic        jump;
    logic [31:0] addr;
    logic        step_en;
    logic        step;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t        vecs [19];
  logic [31:0] prog_a [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      i_load_valid = 1'b1;
      i_load_byte  = w[31-8*b -: 8];
      tick();
    end
    i_load_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic jp, input logic [31:0] ad,
                              input logic se, input logic sp, input logic [31:0] pc,
                              input logic [31:0] ins, input logic [31:0] p4);
    vec_t v;
    v.stall = st; v.jump = jp; v.addr = ad; v.step_en = se; v.step = sp;
    v.exp_pc = pc; v.exp_instr = ins; v.exp_pc4 = p4;
    return v;
  endfunction

  initial begin
    prog_a[0] = 32'h2008_0005;
    prog_a[1] = 32'h2009_0007;
    for (int i = 2; i < 20; i++) prog_a[i] = 32'h1100_0000 + 32'(i);

    vecs[0]  = mk(0, 0, 0,     0, 0, 32'h04, prog_a[0],  32'h04);
    vecs[1]  = mk(0, 0, 0,     0, 0, 32'h08, prog_a[1],  32'h08);
    vecs[2]  = mk(1, 0, 0,     0, 0, 32'h08, prog_a[1],  32'h08);
    vecs[3]  = mk(1, 0, 0,     0, 0, 32'h08, prog_a[1],  32'h08);
    vecs[4]  = mk(1, 0, 0,     0, 0, 32'h08, prog_a[1],  32'h08);
    vecs[5]  = mk(0, 0, 0,     0, 0, 32'h0C, prog_a[2],  32'h0C);
    vecs[6]  = mk(0, 0, 0,     0, 0, 32'h10, prog_a[3],  32'h10);
    vecs[7]  = mk(1, 1, 32'h40, 0, 0, 32'h10, prog_a[3], 32'h10);
    vecs[8]  = mk(0, 1, 32'h40, 0, 0, 32'h40, 32'h0,     32'h0);
    vecs[9]  = mk(0, 0, 0,     0, 0, 32'h44, prog_a[16], 32'h44);
    vecs[10] = mk(0, 0, 0,     1, 0, 32'h44, prog_a[16], 32'h44);
    vecs[11] = mk(0, 0, 0,     1, 0, 32'h44, prog_a[16], 32'h44);
    vecs[12] = mk(0, 0, 0,     1, 0, 32'h44, prog_a[16], 32'h44);
    vecs[13] = mk(0, 0, 0,     1, 0, 32'h44, prog_a[16], 32'h44);
    vecs[14] = mk(0, 0, 0,     1, 0, 32'h44, prog_a[16], 32'h44);
    vecs[15] = mk(0, 0, 0,     1, 1, 32'h48, prog_a[17], 32'h48);
    vecs[16] = mk(0, 0, 0,     1, 0, 32'h48, prog_a[17], 32'h48);
    vecs[17] = mk(0, 0, 0,     1, 1, 32'h4C, prog_a[18], 32'h4C);
    vecs[18] = mk(0, 0, 0,     1, 1, 32'h50, prog_a[19], 32'h50);

    i_rst_n = 1'b0; i_load_valid = 1'b0; i_load_byte = '0; i_start = 1'b0;
    i_reload = 1'b0; i_step_en = 1'b0; i_step = 1'b0; i_stall = 1'b0;
    i_jump = 1'b0; i_addr2jump = '0;
    #1;
    check("rst_pc", o_pc, 32'h0);
    check("rst_instr", o_instruction, 32'h0);
    check("rst_pc4", o_pcounter4, 32'h0);
    check("rst_halt", 32'(o_halt), 32'h0);
    check("rst_state", 32'(o_state), 32'h0);
    check("rst_words", 32'(o_load_words), 32'h0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    tick();

    // Program A: first two words from the loader example
    load_word(prog_a[0]);
    load_word(prog_a[1]);
    check("load2_words", 32'(o_load_words), 32'd2);
    for (int i = 2; i < 20; i++) load_word(prog_a[i]);
    check("load20_words", 32'(o_load_words), 32'd20);
    check("load_state", 32'(o_state), 32'd0);

    i_start = 1'b1; tick(); i_start = 1'b0;
    check("start_state", 32'(o_state), 32'd1);
    check("start_pc", o_pc, 32'h0);
    check("start_instr", o_instruction, 32'h0);

    for (int v = 0; v < 19; v++) begin
      i_stall = vecs[v].stall; i_jump = vecs[v].jump; i_addr2jump = vecs[v].addr;
      i_step_en = vecs[v].step_en; i_step = vecs[v].step;
      tick();
      check($sformatf("vec%0d_pc", v), o_pc, vecs[v].exp_pc);
      check($sformatf("vec%0d_instr", v), o_instruction, vecs[v].exp_instr);
      check($sformatf("vec%0d_pc4", v), o_pcounter4, vecs[v].exp_pc4);
    end
    i_stall = 1'b0; i_jump = 1'b0; i_addr2jump = '0; i_step_en = 1'b0; i_step = 1'b0;

    // Asynchronous reset mid-RUN, between clock edges
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_pc", o_pc, 32'h0);
    check("arst_instr", o_instruction, 32'h0);
    check("arst_pc4", o_pcounter4, 32'h0);
    check("arst_halt", 32'(o_halt), 32'h0);
    check("arst_state", 32'(o_state), 32'h0);
    check("arst_words", 32'(o_load_words), 32'h0);
    @(negedge clk);
    i_rst_n = 1'b1;
    tick();

    // Program B: HALT at byte address 0x0C; trailing partial word discarded
    load_word(32'h2222_0000);
    load_word(32'h2222_0001);
    load_word(32'h2222_0002);
    load_word(32'hFFFF_FFFF);
    i_load_valid = 1'b1; i_load_byte = 8'hAB; tick();
    i_load_byte = 8'hCD; tick();
    i_load_valid = 1'b0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    check("partial_words", 32'(o_load_words), 32'd4);
    check("b_start_state", 32'(o_state), 32'd1);
    tick();
    check("b0_instr", o_instruction, 32'h2222_0000);
    tick(); tick();
    check("b2_instr", o_instruction, 32'h2222_0002);
    check("b2_pc", o_pc, 32'h0C);
    tick();
    check("halt_flag", 32'(o_halt), 32'd1);
    check("halt_state", 32'(o_state), 32'd2);
    check("halt_instr", o_instruction, 32'h0);
    check("halt_pc", o_pc, 32'h0C);
    i_load_valid = 1'b1; i_load_byte = 8'h55;
    tick();
    i_load_valid = 1'b0;
    check("halt_hold_pc", o_pc, 32'h0C);
    check("halt_hold_words", 32'(o_load_words), 32'd4);

    i_start = 1'b1; i_reload = 1'b1; tick(); i_start = 1'b0; i_reload = 1'b0;
    check("restart_state", 32'(o_state), 32'd1);
    check("restart_pc", o_pc, 32'h0);
    check("restart_halt", 32'(o_halt), 32'd0);
    tick();
    check("restart_instr", o_instruction, 32'h2222_0000);
    check("restart_pc4", o_pcounter4, 32'h4);
    repeat (3) tick();
    check("rehalt_state", 32'(o_state), 32'd2);

    i_reload = 1'b1; tick(); i_reload = 1'b0;
    check("reload_state", 32'(o_state), 32'd0);
    check("reload_words", 32'(o_load_words), 32'd0);

    // 257 words: pointer wraps, count saturates at depth
    for (int k = 0; k < 257; k++) load_word(32'h3000_0000 + 32'(k));
    check("wrap_words", 32'(o_load_words), 32'd256);
    i_start = 1'b1; tick(); i_start = 1'b0;
    tick();
    check("wrap_mem0", o_instruction, 32'h3000_0100);
    check("wrap_pc4_0", o_pcounter4, 32'h4);
    tick();
    check("wrap_mem1", o_instruction, 32'h3000_0001);
    check("wrap_pc4_1", o_pcounter4, 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

IF stage of the 5-stage MIPS pipeline: holds the PC and a word-addressed instruction memory, and registers the IF/ID pair (instruction, PC+4) consumed by `instruction_decode`. Before execution, the debug unit loads the program byte-wise into the memory. During run, the block redirects the PC on decode's jump/branch, honours the hazard-unit stall, supports single-step, and stops on a HALT word.

## Interface
Parameters:
- NB_DATA, 32, instruction/PC width
- NB_ADDR, 8, instruction-memory word-address bits (depth 2^NB_ADDR)
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_load_valid  in  1  one program byte present (LOAD state only)
- i_load_byte  in  8  program byte, big-endian order within each word
- i_start  in  1  pulse: LOAD/HALT -> RUN, PC restarts at 0
- i_reload  in  1  pulse: HALT -> LOAD, load pointer cleared
- i_step_en  in  1  1 = single-step mode
- i_step  in  1  pulse: advance one instruction in step mode
- i_stall  in  1  hazard stall: hold PC and IF/ID
- i_jump  in  1  redirect request from decode (combinational there)
- i_addr2jump  in  NB_DATA  redirect target (byte address)
- o_instruction  out  NB_DATA  IF/ID instruction
- o_pcounter4  out  NB_DATA  IF/ID PC+4 of o_instruction
- o_pc  out  NB_DATA  current PC
- o_halt  out  1  HALT word fetched, fetch frozen
- o_state  out  2  LOAD=0, RUN=1, HALT=2
- o_load_words  out  NB_ADDR+1  words written since entering LOAD, saturating at 2^NB_ADDR

## Operation
- Reset values: PC 0; o_instruction 0 (NOP); o_pcounter4 0; o_halt 0; state LOAD; byte counter 0; load pointer 0; o_load_words 0. Memory contents are not reset.
- LOAD:
  - Each i_load_valid shifts a byte into a 32-bit assembler; the first byte lands in [31:24].
  - On the 4th byte, write the word at the load pointer, increment the pointer (wraps at depth, overwriting), clear the byte counter.
  - i_start discards a partial word and goes to RUN.
- RUN: an advance enable `adv` = !i_stall && (!i_step_en || i_step). Priority per edge:
  - !adv: PC and IF/ID hold.
  - i_jump: PC <= i_addr2jump; o_instruction <= 0 (flush wrong-path word); o_pcounter4 <= 0.
  - mem[PC] == HALT_WORD: o_instruction <= 0, o_halt <= 1, PC holds, state HALT.
  - Otherwise: o_instruction <= mem[PC]; o_pcounter4 <= PC+4; PC <= PC+4.
- Memory index is PC[NB_ADDR+1:2]. PC bits [1:0] are ignored. An out-of-range PC wraps modulo depth.
- HALT:
  - IF/ID holds NOP, so the downstream pipeline drains.
  - i_start: o_halt <= 0, PC <= 0, RUN.
  - i_reload: LOAD, pointer/counters cleared.
  - i_start and i_reload together: i_start wins.
- i_load_valid outside LOAD, and i_start inside RUN, are ignored.

## Timing
- Memory: asynchronous read, synchronous write. Fetch latency is 1 cycle (PC -> o_instruction on the next edge).
- A jump asserted in cycle n: target word appears on o_instruction at edge n+2. The single wrong-path slot becomes NOP at edge n+1.
- Stall dominates jump. Decode holds its registers, so i_jump persists and is taken on the first unstalled edge.
- Step mode: exactly one advance per i_step-high edge. A held i_step advances every cycle.
- Reset mid-load or mid-run returns to LOAD immediately (async). Loaded memory is kept, but o_load_words restarts at 0.

## Structure
- A shared package `mips_pkg` holds NB_DATA, the state encodings LOAD/RUN/HALT, HALT_WORD and NOP_WORD (0), shared with the debug unit.
- One sub-module, `instruction_memory`: sync write port, async read port, parameterised by NB_ADDR/NB_DATA.
- The FSM, PC, byte assembler and IF/ID register live in `instruction_fetch`.

## Test plan
- Load bytes 20,08,00,05 then 20,09,00,07 -> mem[0]=0x20080005, mem[1]=0x20090007, o_load_words=2. i_start -> o_instruction 0x20080005 / o_pcounter4 4, then 0x20090007 / 8.
- Run with i_stall high for 3 cycles at PC=8 -> o_pc=8 and IF/ID unchanged for 3 edges, then resume at 0x... mem[2] with o_pcounter4=12.
- i_jump=1, i_addr2jump=0x40 while fetching PC=0x10 -> next o_instruction=0, o_pc=0x40, then o_instruction=mem[16], o_pcounter4=0x44.
- Word HALT_WORD at address 0x0C -> o_halt=1 and o_state=2 after edge, o_instruction=0, PC stays 0x0C. i_start -> PC 0, o_halt 0.
- Step mode: i_step_en=1, no i_step for 5 cycles -> PC constant. Two i_step pulses -> PC +8.
- Assert i_rst_n low mid-RUN -> all outputs to reset values asynchronously, state LOAD. Write 257 words with NB_ADDR=8 -> pointer wraps and mem[0] holds word 256, o_load_words=256.
